weight_buf_loader: RTL and testbench

Packs the DMA word stream into full-width weight lines and writes them into the weight single-port SRAM wrapper at consecutive addresses. It sits directly upstream of the weight buffer and owns its only port. When idle, it also multiplexes read requests from the compute array onto the same port. Reads use the wrapper's 1-cycle read latency (N_DELAY = 1).

---
 rtl/weight_buf_loader_if.sv | 44 ++++
 rtl/weight_buf_loader.sv | 255 +++++++++++++++++++++++++
 tb/tb_weight_buf_loader.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/weight_buf_loader_if.sv
// -----------------------------------------------------------------------------
// weight_buf_loader_if
// Bus bundles used by weight_buf_loader.
//
// wbuf_stream_if : DMA word stream (valid/ready handshake)
//   s_valid  word valid            (master -> slave)
//   s_data   stream word, IW bits  (master -> slave)
//   s_last   last word of transfer (master -> slave)
//   s_ready  stream ready          (slave  -> master)
//
// wbuf_mem_if : single-port SRAM wrapper port
//   mem_cs    chip select          (master -> slave)
//   mem_we    write enable         (master -> slave)
//   mem_addr  line address, AW     (master -> slave)
//   mem_wdata write line, DW       (master -> slave)
//   mem_rdata read line, DW        (slave  -> master, 1-cycle latency)
// -----------------------------------------------------------------------------
interface wbuf_stream_if #(
    parameter int IW = 32
);
    logic          s_valid;
    logic [IW-1:0] s_data;
    logic          s_last;
    logic          s_ready;

    modport master (output s_valid, output s_data, output s_last, input s_ready);
    modport slave  (input s_valid, input s_data, input s_last, output s_ready);
endinterface

interface wbuf_mem_if #(
    parameter int DW = 128,
    parameter int AW = 4
);
    logic          mem_cs;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport master (output mem_cs, output mem_we, output mem_addr, output mem_wdata,
                    input mem_rdata);
    modport slave  (input mem_cs, input mem_we, input mem_addr, input mem_wdata,
                    output mem_rdata);
endinterface

// File: rtl/weight_buf_loader.sv
// -----------------------------------------------------------------------------
// weight_buf_loader
// Packs IW-bit DMA words into DW-bit weight lines (first word in the LSBs) and
// writes them to consecutive addresses of the weight single-port SRAM. While
// idle, compute-array reads are multiplexed onto the same SRAM port
// (1-cycle read latency).
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   start      one-cycle load request (honoured only in IDLE)
//   num_lines  lines to load, latched on start, clamped to DEPTH
//   busy       high in LOAD and DONE
//   done       one-cycle pulse at end of a load
//   err        sticky framing error, cleared by the next accepted start
//   rd_en      compute read request
//   rd_addr    compute read address
//   rd_valid   rd_data valid (one cycle after an honoured rd_en)
//   rd_data    read line, passes mem_rdata through
//   s          DMA stream (wbuf_stream_if.slave)
//   m          SRAM port  (wbuf_mem_if.master)
//
// Build option:
//   WBUF_ZERO_PAD_EN  when defined, a partial line terminated by an early
//                     s_last is zero-filled and written; otherwise discarded.
// -----------------------------------------------------------------------------
module weight_buf_loader #(
    parameter int IW    = 32,
    parameter int DW    = 128,
    parameter int AW    = 4,
    parameter int DEPTH = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW:0]   num_lines,
    output logic          busy,
    output logic          done,
    output logic          err,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic          rd_valid,
    output logic [DW-1:0] rd_data,
    wbuf_stream_if.slave  s,
    wbuf_mem_if.master    m
);

    localparam int R  = DW / IW;
    localparam int KW = $clog2(R);
    localparam logic [AW:0]   NL_MAX  = (AW+1)'(DEPTH);
    localparam logic [KW-1:0] K_LAST  = KW'(R - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t        state_r;
    logic [KW-1:0] k_r;
    logic [AW:0]   n_r;
    logic [AW:0]   nl_r;
    logic [DW-1:0] line_r;
    logic          wr_pending_r;
    logic [AW-1:0] wr_addr_r;
    logic [DW-1:0] wr_data_r;
    logic          err_r;
    logic          busy_r;
    logic          done_r;
    logic          s_ready_r;
    logic          rd_valid_r;

    logic          hs_s;
    logic          line_full_s;
    logic          final_word_s;
    logic [AW:0]   clamp_s;
    logic [DW-1:0] merged_line_s;
    logic          rd_sel_s;

    // Handshake and line/load position decode
    always_comb begin
        hs_s         = s.s_valid & s_ready_r;
        line_full_s  = (k_r == K_LAST);
        final_word_s = line_full_s & (n_r == (nl_r - (AW+1)'(1)));
    end

    // Clamp the requested line count to the buffer depth
    always_comb begin
        if (num_lines > NL_MAX) begin
            clamp_s = NL_MAX;
        end else begin
            clamp_s = num_lines;
        end
    end

    // Current line with the incoming word inserted at slot k; slots above k
    // are still zero because the line register is cleared at each line start
    always_comb begin
        merged_line_s = line_r;
        for (int i = 0; i < R; i++) begin
            if (k_r == KW'(i)) begin
                merged_line_s[i*IW +: IW] = s.s_data;
            end else begin
                merged_line_s[i*IW +: IW] = line_r[i*IW +: IW];
            end
        end
    end

    // Read requests are honoured only in IDLE with no line write outstanding
    always_comb begin
        if (!rst && (state_r == ST_IDLE) && !wr_pending_r && rd_en) begin
            rd_sel_s = 1'b1;
        end else begin
            rd_sel_s = 1'b0;
        end
    end

    // SRAM port mux: a pending line write always owns the port
    always_comb begin
        m.mem_cs   = 1'b0;
        m.mem_we   = 1'b0;
        m.mem_addr = wr_addr_r;
        if (rst) begin
            m.mem_cs   = 1'b0;
            m.mem_we   = 1'b0;
            m.mem_addr = wr_addr_r;
        end else if (wr_pending_r) begin
            m.mem_cs   = 1'b1;
            m.mem_we   = 1'b1;
            m.mem_addr = wr_addr_r;
        end else if (rd_sel_s) begin
            m.mem_cs   = 1'b1;
            m.mem_we   = 1'b0;
            m.mem_addr = rd_addr;
        end else begin
            m.mem_cs   = 1'b0;
            m.mem_we   = 1'b0;
            m.mem_addr = wr_addr_r;
        end
    end

    // Output drive from registers
    always_comb begin
        m.mem_wdata = wr_data_r;
        s.s_ready   = s_ready_r;
        busy        = busy_r;
        done        = done_r;
        err         = err_r;
        rd_valid    = rd_valid_r;
        rd_data     = m.mem_rdata;
    end

    // Load FSM, line packer, write register and read-valid tracking
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            k_r          <= '0;
            n_r          <= '0;
            nl_r         <= '0;
            line_r       <= '0;
            wr_pending_r <= 1'b0;
            wr_addr_r    <= '0;
            wr_data_r    <= '0;
            err_r        <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            s_ready_r    <= 1'b0;
            rd_valid_r   <= 1'b0;
        end else begin
            wr_pending_r <= 1'b0;
            done_r       <= 1'b0;
            rd_valid_r   <= rd_sel_s;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        err_r  <= 1'b0;
                        k_r    <= '0;
                        n_r    <= '0;
                        line_r <= '0;
                        nl_r   <= clamp_s;
                        busy_r <= 1'b1;
                        if (clamp_s == (AW+1)'(0)) begin
                            state_r   <= ST_DONE;
                            done_r    <= 1'b1;
                            s_ready_r <= 1'b0;
                        end else begin
                            state_r   <= ST_LOAD;
                            s_ready_r <= 1'b1;
                        end
                    end else begin
                        busy_r    <= 1'b0;
                        s_ready_r <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (hs_s) begin
                        if (line_full_s) begin
                            // Full line: hand it to the write register, keep streaming
                            wr_pending_r <= 1'b1;
                            wr_addr_r    <= n_r[AW-1:0];
                            wr_data_r    <= merged_line_s;
                            line_r       <= '0;
                            k_r          <= '0;
                            n_r          <= n_r + (AW+1)'(1);
                        end else begin
                            line_r <= merged_line_s;
                            k_r    <= k_r + KW'(1);
                        end
                        if (final_word_s) begin
                            if (!s.s_last) begin
                                err_r <= 1'b1;
                            end else begin
                                err_r <= err_r;
                            end
                            state_r   <= ST_DONE;
                            done_r    <= 1'b1;
                            s_ready_r <= 1'b0;
                        end else if (s.s_last) begin
                            // Early end of transfer
                            err_r     <= 1'b1;
                            state_r   <= ST_DONE;
                            done_r    <= 1'b1;
                            s_ready_r <= 1'b0;
                            line_r    <= '0;
`ifdef WBUF_ZERO_PAD_EN
                            if (!line_full_s) begin
                                wr_pending_r <= 1'b1;
                                wr_addr_r    <= n_r[AW-1:0];
                                wr_data_r    <= merged_line_s;
                            end else begin
                                wr_pending_r <= 1'b1;
                            end
`endif
                        end else begin
                            state_r <= ST_LOAD;
                        end
                    end else begin
                        state_r <= ST_LOAD;
                    end
                end
                ST_DONE: begin
                    state_r   <= ST_IDLE;
                    busy_r    <= 1'b0;
                    s_ready_r <= 1'b0;
                end
                default: begin
                    state_r   <= ST_IDLE;
                    busy_r    <= 1'b0;
                    s_ready_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_weight_buf_loader.sv
module tb_weight_buf_loader;

    localparam int IW    = 32;
    localparam int DW    = 128;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int R     = DW / IW;

    typedef struct {
        int            addr;
        logic [DW-1:0] data;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW:0]   num_lines;
    logic          busy;
    logic          done;
    logic          err;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic          rd_valid;
    logic [DW-1:0] rd_data;

    int checks   = 0;
    int failures = 0;

    wr_t           exp_wr_q[$];
    logic [DW-1:0] exp_rd_q[$];
    logic [DW-1:0] ref_mem[DEPTH];
    logic [DW-1:0] sram[DEPTH];
    logic [DW-1:0] tmp_line;
    wr_t           mon_wr;
    logic [DW-1:0] mon_rd;

    wbuf_stream_if #(.IW(IW))         st();
    wbuf_mem_if    #(.DW(DW), .AW(AW)) mm();

    weight_buf_loader #(.IW(IW), .DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .num_lines (num_lines),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .s         (st),
        .m         (mm)
    );

    always #5 clk = ~clk;

    // SRAM wrapper model, 1-cycle read latency
    always @(posedge clk) begin
        if (mm.mem_cs) begin
            if (mm.mem_we) sram[mm.mem_addr] <= mm.mem_wdata;
            else           mm.mem_rdata <= sram[mm.mem_addr];
        end
    end

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Monitor: every write and every read response is popped and compared
    always @(negedge clk) begin
        if (mm.mem_cs && mm.mem_we) begin
            if (exp_wr_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write actual_addr=%0d required=none", mm.mem_addr);
            end else begin
                mon_wr = exp_wr_q.pop_front();
                chk("wr_addr", DW'(mm.mem_addr), DW'(mon_wr.addr));
                chk("wr_data", mm.mem_wdata, mon_wr.data);
            end
        end
        if (rd_valid) begin
            if (exp_rd_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_rd_valid actual=1 required=0");
            end else begin
                mon_rd = exp_rd_q.pop_front();
                chk("rd_data", rd_data, mon_rd);
            end
        end
    end

    task automatic check_reset_vals(input string tag);
        chk({tag, "_s_ready"},   DW'(st.s_ready),   '0);
        chk({tag, "_busy"},      DW'(busy),         '0);
        chk({tag, "_done"},      DW'(done),         '0);
        chk({tag, "_err"},       DW'(err),          '0);
        chk({tag, "_rd_valid"},  DW'(rd_valid),     '0);
        chk({tag, "_mem_cs"},    DW'(mm.mem_cs),    '0);
        chk({tag, "_mem_we"},    DW'(mm.mem_we),    '0);
        chk({tag, "_mem_addr"},  DW'(mm.mem_addr),  '0);
        chk({tag, "_mem_wdata"}, mm.mem_wdata,      '0);
    endtask

    // One load: reference model derives expected writes from the word list,
    // then the stream is driven and the end-of-load status checked.
    task automatic do_load(input int nl, input bit seq, input int last_at,
                           input bit thr, input bit noise);
        int nlc, total, term, nfull, npart;
        bit early, exp_err;
        int wv[64];
        logic [DW-1:0] ln;
        wr_t w;
        nlc   = (nl > DEPTH) ? DEPTH : nl;
        total = nlc * R;
        for (int j = 0; j < 64; j++) wv[j] = seq ? j : int'($urandom);
        if (nlc == 0) begin
            @(negedge clk); start = 1'b1; num_lines = (AW+1)'(nl);
            @(negedge clk); start = 1'b0;
            chk("zero_done",        DW'(done),       DW'(1));
            chk("zero_err_cleared", DW'(err),        '0);
            chk("zero_s_ready",     DW'(st.s_ready), '0);
            @(negedge clk);
            chk("zero_idle_done",   DW'(done),       '0);
            chk("zero_idle_busy",   DW'(busy),       '0);
            return;
        end
        term  = total - 1;
        early = 1'b0;
        if (last_at >= 0 && last_at < total - 1) begin
            term  = last_at;
            early = 1'b1;
        end
        exp_err = early || (last_at != total - 1);
        nfull = (term + 1) / R;
        npart = (term + 1) % R;
        for (int l = 0; l < nfull; l++) begin
            ln = '0;
            for (int q = 0; q < R; q++) ln[q*IW +: IW] = wv[l*R + q];
            w.addr = l; w.data = ln;
            exp_wr_q.push_back(w);
            ref_mem[l] = ln;
        end
`ifdef WBUF_ZERO_PAD_EN
        if (npart != 0) begin
            ln = '0;
            for (int q = 0; q < npart; q++) ln[q*IW +: IW] = wv[nfull*R + q];
            w.addr = nfull; w.data = ln;
            exp_wr_q.push_back(w);
            ref_mem[nfull] = ln;
        end
`else
        if (npart != 0) ln = '0;
`endif
        @(negedge clk); start = 1'b1; num_lines = (AW+1)'(nl);
        @(negedge clk); start = 1'b0;
        chk("start_s_ready",     DW'(st.s_ready), DW'(1));
        chk("start_busy",        DW'(busy),       DW'(1));
        chk("start_err_cleared", DW'(err),        '0);
        for (int j = 0; j <= term; j++) begin
            rd_en   = noise;
            rd_addr = AW'($urandom);
            if (thr && (j % 2 == 1)) begin
                st.s_valid = 1'b0;
                @(negedge clk);
            end
            st.s_valid = 1'b1;
            st.s_data  = wv[j];
            st.s_last  = (j == last_at);
            if (noise) begin
                #1;
                chk("busy_read_blocked", DW'(mm.mem_cs && !mm.mem_we), '0);
            end
            @(negedge clk);
        end
        st.s_valid = 1'b0;
        st.s_last  = 1'b0;
        chk("done_pulse", DW'(done), DW'(1));
        chk("done_busy",  DW'(busy), DW'(1));
        chk("done_err",   DW'(err),  DW'(exp_err));
        @(negedge clk);
        rd_en = 1'b0;
        chk("idle_done",    DW'(done),       '0);
        chk("idle_busy",    DW'(busy),       '0);
        chk("idle_s_ready", DW'(st.s_ready), '0);
        chk("err_sticky",   DW'(err),        DW'(exp_err));
    endtask

    task automatic readback(input int first, input int cnt);
        for (int a = first; a < first + cnt; a++) begin
            @(negedge clk);
            rd_en   = 1'b1;
            rd_addr = AW'(a);
            exp_rd_q.push_back(ref_mem[a]);
            #1;
            chk("rd_port_cs",   DW'(mm.mem_cs),   DW'(1));
            chk("rd_port_we",   DW'(mm.mem_we),   '0);
            chk("rd_port_addr", DW'(mm.mem_addr), DW'(a));
        end
        @(negedge clk);
        rd_en = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nl, la;
        rst = 1'b1; start = 1'b0; num_lines = '0; rd_en = 1'b0; rd_addr = '0;
        st.s_valid = 1'b0; st.s_data = '0; st.s_last = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        rst = 1'b0;

        // Full load of 16 lines, words 0..63, then readback
        do_load(16, 1'b1, 63, 1'b0, 1'b0);
        readback(0, DEPTH);
        @(negedge clk); rd_en = 1'b1; rd_addr = AW'(5);
        exp_rd_q.push_back({32'd23, 32'd22, 32'd21, 32'd20});
        @(negedge clk); rd_en = 1'b0;
        @(negedge clk);

        // Throttled stream with reads attempted while busy
        do_load(2, 1'b1, 7, 1'b1, 1'b1);
        readback(0, 2);

        // Early s_last on word 5
        do_load(4, 1'b1, 5, 1'b0, 1'b0);
        readback(0, 4);

        // Missing s_last, then a zero-line load
        do_load(1, 1'b0, -1, 1'b0, 1'b0);
        do_load(0, 1'b0, -1, 1'b0, 1'b0);
        readback(0, 1);

        // Clamped line count
        do_load(20, 1'b0, 63, 1'b0, 1'b0);
        readback(0, DEPTH);

        // Random loads
        for (int it = 0; it < 4; it++) begin
            nl = int'($urandom_range(1, DEPTH));
            la = int'($urandom_range(0, nl * R + 2));
            if (la > nl * R - 1) la = -1;
            if ($urandom_range(0, 1) == 1) la = nl * R - 1;
            do_load(nl, 1'b0, la, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            readback(0, DEPTH);
        end

        // Reset in the middle of a 4-line load, after word 6
        @(negedge clk);
        tmp_line = '0;
        for (int q = 0; q < R; q++) tmp_line[q*IW +: IW] = 32'h100 + q;
        mon_wr.addr = 0; mon_wr.data = tmp_line;
        exp_wr_q.push_back(mon_wr);
        ref_mem[0] = tmp_line;
        start = 1'b1; num_lines = (AW+1)'(4);
        @(negedge clk); start = 1'b0;
        for (int j = 0; j <= 6; j++) begin
            st.s_valid = 1'b1;
            st.s_data  = 32'h100 + j;
            st.s_last  = 1'b0;
            @(negedge clk);
        end
        st.s_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check_reset_vals("midload_reset");
        rst = 1'b0;
        @(negedge clk);
        readback(0, 1);

        readback(0, DEPTH);
        repeat (3) @(negedge clk);
        chk("wr_queue_drained", DW'(exp_wr_q.size()), '0);
        chk("rd_queue_drained", DW'(exp_rd_q.size()), '0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
